// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch stage: branch/jump select codes,
// fetch state encodings and default parameters.
package fetch_pkg;

  // selbrjumpz encodings driven by the control decoder
  localparam logic [1:0] BRJ_SEQ = 2'b00;
  localparam logic [1:0] BRJ_JR  = 2'b01;
  localparam logic [1:0] BRJ_J   = 2'b10;
  localparam logic [1:0] BRJ_BR  = 2'b11;

  // Fetch state machine encodings
  typedef logic [2:0] state_t;
  localparam state_t IDLE = 3'd0;
  localparam state_t REQ  = 3'd1;
  localparam state_t WAIT = 3'd2;
  localparam state_t HOLD = 3'd3;
  localparam state_t DROP = 3'd4;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          MAX_WAIT_DEFAULT = 255;

endpackage

// File: rtl/next_pc_calc.sv
// Redirect target computation: decides whether the decoder's control decision
// changes the fetch PC and, if so, where to.
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic        redir_valid,
  input  logic [1:0]  selbrjumpz,
  input  logic        br_taken,
  input  logic [31:0] rs_value,
  input  logic [31:0] redir_pc,
  input  logic [15:0] imm16,
  input  logic [25:0] jidx26,
  output logic [31:0] target,
  output logic        redir_en
);

  logic [31:0] pc4;
  logic [31:0] br_off;

  assign pc4    = redir_pc + 32'd4;
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

  // Select the target and whether the decision actually redirects fetch
  always_comb begin
    target   = pc4;
    redir_en = 1'b0;
    case (selbrjumpz)
      BRJ_JR: begin
        target   = {rs_value[31:2], 2'b00};
        redir_en = redir_valid;
      end
      BRJ_J: begin
        target   = {pc4[31:28], jidx26, 2'b00};
        redir_en = redir_valid;
      end
      BRJ_BR: begin
        target   = pc4 + br_off;
        redir_en = redir_valid & br_taken;
      end
      default: begin
        target   = pc4;
        redir_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch stage. Requests one word from imem,
// holds it for decode, and flushes or drops stale fetches on a redirect.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [5:0]  op,
  output logic [5:0]  fn,
  input  logic        redir_valid,
  input  logic [1:0]  selbrjumpz,
  input  logic        br_taken,
  input  logic [31:0] rs_value,
  input  logic [31:0] redir_pc,
  input  logic [15:0] imm16,
  input  logic [25:0] jidx26,
  output logic        fetch_err
);

  // Last counter value before the response wait gives up
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] inst_reg;
  logic [31:0] inst_pc_reg;
  logic        inst_valid_reg;
  logic        fetch_err_reg;
  logic [7:0]  wait_cnt_reg;
  logic [31:0] target;
  logic        redir_en;

  next_pc_calc u_next_pc_calc (
    .redir_valid (redir_valid),
    .selbrjumpz  (selbrjumpz),
    .br_taken    (br_taken),
    .rs_value    (rs_value),
    .redir_pc    (redir_pc),
    .imm16       (imm16),
    .jidx26      (jidx26),
    .target      (target),
    .redir_en    (redir_en)
  );

  // Fetch sequencing; a redirect overrides pc and flushes the held word in any state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      inst_reg       <= '0;
      inst_pc_reg    <= '0;
      inst_valid_reg <= 1'b0;
      fetch_err_reg  <= 1'b0;
      wait_cnt_reg   <= '0;
    end else begin
      if (redir_en) begin
        pc_reg         <= target;
        inst_valid_reg <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          // A redirect here only updates pc; the request goes out next cycle
          if (!redir_en) state_reg <= REQ;
        end
        REQ: begin
          // Without ack the address simply follows pc, so a redirect retargets
          if (imem_ack) begin
            wait_cnt_reg <= '0;
            state_reg    <= redir_en ? DROP : WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (!redir_en) begin
              inst_reg       <= imem_rdata;
              inst_pc_reg    <= pc_reg;
              inst_valid_reg <= 1'b1;
              state_reg      <= HOLD;
            end else begin
              state_reg <= IDLE;
            end
          end else if (wait_cnt_reg == WAIT_LAST) begin
            fetch_err_reg <= 1'b1;
            state_reg     <= IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
            if (redir_en) state_reg <= DROP;
          end
        end
        HOLD: begin
          if (redir_en) begin
            state_reg <= IDLE;
          end else if (inst_ready) begin
            inst_valid_reg <= 1'b0;
            pc_reg         <= pc_reg + 32'd4;
            state_reg      <= IDLE;
          end
        end
        DROP: begin
          // Stale response is discarded; pc already holds the redirect target
          if (imem_rvalid) begin
            state_reg <= IDLE;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            fetch_err_reg <= 1'b1;
            state_reg     <= IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign imem_req   = (state_reg == REQ);
  assign imem_addr  = pc_reg;
  assign inst_valid = inst_valid_reg;
  assign inst       = inst_reg;
  assign inst_pc    = inst_pc_reg;
  assign op         = inst_reg[31:26];
  assign fn         = inst_reg[5:0];
  assign fetch_err  = fetch_err_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: an imem responder driven from the
// stimulus thread and a scoreboard of instructions expected at decode.
module tb_instr_fetch;

  logic        clock;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [5:0]  op;
  logic [5:0]  fn;
  logic        redir_valid;
  logic [1:0]  selbrjumpz;
  logic        br_taken;
  logic [31:0] rs_value;
  logic [31:0] redir_pc;
  logic [15:0] imm16;
  logic [25:0] jidx26;
  logic        fetch_err;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  instr_fetch dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .op          (op),
    .fn          (fn),
    .redir_valid (redir_valid),
    .selbrjumpz  (selbrjumpz),
    .br_taken    (br_taken),
    .rs_value    (rs_value),
    .redir_pc    (redir_pc),
    .imm16       (imm16),
    .jidx26      (jidx26),
    .fetch_err   (fetch_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bounded wait for a fetch request, then check its address
  task automatic wait_req(input logic [31:0] addr, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (imem_req) seen = 1'b1;
      else @(negedge clock);
    end
    check_eq({tag, "_req"}, 32'(seen), 32'd1);
    check_eq({tag, "_addr"}, imem_addr, addr);
  endtask

  // Bounded wait for inst_valid, then pop the scoreboard and compare
  task automatic expect_inst(input string tag);
    bit   seen = 1'b0;
    exp_t e;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (inst_valid) seen = 1'b1;
      else @(negedge clock);
    end
    check_eq({tag, "_valid"}, 32'(seen), 32'd1);
    if (seen) begin
      if (exp_q.size() == 0) begin
        check_eq({tag, "_sb_entry"}, 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq({tag, "_inst"}, inst, e.data);
        check_eq({tag, "_pc"}, inst_pc, e.pc);
        check_eq({tag, "_op"}, 32'(op), 32'(e.data[31:26]));
        check_eq({tag, "_fn"}, 32'(fn), 32'(e.data[5:0]));
        $display("inst %s pc=%h data=%h op=%h fn=%h", tag, inst_pc, inst, op, fn);
      end
    end
  endtask

  // Request, immediate ack, response one cycle later, then decode sees it
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input string tag);
    wait_req(addr, tag);
    imem_ack = 1'b1;
    @(negedge clock);
    imem_ack = 1'b0;
    check_eq({tag, "_req_drop"}, 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    exp_q.push_back(exp_t'({addr, data}));
    @(negedge clock);
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    expect_inst(tag);
  endtask

  task automatic accept();
    inst_ready = 1'b1;
    @(negedge clock);
    inst_ready = 1'b0;
  endtask

  // One-cycle control decision from the decoder
  task automatic redirect(input logic [1:0] sel, input logic taken, input logic [31:0] rs,
                          input logic [31:0] rpc, input logic [15:0] imm, input logic [25:0] jidx);
    redir_valid = 1'b1;
    selbrjumpz  = sel;
    br_taken    = taken;
    rs_value    = rs;
    redir_pc    = rpc;
    imm16       = imm;
    jidx26      = jidx;
    @(negedge clock);
    redir_valid = 1'b0;
    selbrjumpz  = 2'b00;
    br_taken    = 1'b0;
  endtask

  initial begin
    int cycles;
    reset_n     = 1'b0;
    imem_ack    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    inst_ready  = 1'b0;
    redir_valid = 1'b0;
    selbrjumpz  = 2'b00;
    br_taken    = 1'b0;
    rs_value    = '0;
    redir_pc    = '0;
    imm16       = '0;
    jidx26      = '0;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_inst", inst, 32'd0);
    check_eq("rst_err", 32'(fetch_err), 32'd0);
    reset_n = 1'b1;

    // First fetch: ADD at address 0
    do_fetch(32'h0000_0000, 32'h0000_0020, "add0");

    // Decode stalls five cycles: word stays put, no new request
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_valid", 32'(inst_valid), 32'd1);
      check_eq("stall_inst", inst, 32'h0000_0020);
      check_eq("stall_noreq", 32'(imem_req), 32'd0);
      @(negedge clock);
    end
    accept();
    check_eq("accept_valid", 32'(inst_valid), 32'd0);

    // Sequential fetch at 4, then jump-register flush while decode is ready
    do_fetch(32'h0000_0004, 32'h8C41_0004, "lw4");
    inst_ready = 1'b1;
    redirect(2'b01, 1'b0, 32'h0000_1003, 32'h0000_0004, 16'h0, 26'h0);
    inst_ready = 1'b0;
    check_eq("jr_flush", 32'(inst_valid), 32'd0);
    wait_req(32'h0000_1000, "jr_tgt");

    // Taken branch from 0x100 with offset -2 words, accepted in the same cycle
    do_fetch(32'h0000_1000, 32'h1000_FFFE, "br1000");
    inst_ready = 1'b1;
    redirect(2'b11, 1'b1, 32'h0, 32'h0000_0100, 16'hFFFE, 26'h0);
    inst_ready = 1'b0;
    wait_req(32'h0000_00FC, "br_tgt");

    // Not-taken branch: handshake proceeds sequentially
    do_fetch(32'h0000_00FC, 32'h1000_0003, "bnt");
    inst_ready = 1'b1;
    redirect(2'b11, 1'b0, 32'h0, 32'h0000_00FC, 16'h0010, 26'h0);
    inst_ready = 1'b0;
    wait_req(32'h0000_0100, "seq_tgt");

    // Jump while the response is outstanding; late data must never surface
    imem_ack = 1'b1;
    @(negedge clock);
    imem_ack = 1'b0;
    redirect(2'b10, 1'b0, 32'h0, 32'h4000_0000, 16'h0, 26'h40);
    for (int i = 0; i < 2; i++) begin
      check_eq("drop_wait_valid", 32'(inst_valid), 32'd0);
      @(negedge clock);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clock);
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    for (int i = 0; i < 3; i++) begin
      check_eq("drop_valid", 32'(inst_valid), 32'd0);
      @(negedge clock);
    end
    do_fetch(32'h4000_0100, 32'h2108_0001, "j_tgt");
    accept();

    // Retarget a request that has not been acked yet
    wait_req(32'h4000_0104, "pre_retgt");
    redirect(2'b01, 1'b0, 32'h0000_2000, 32'h4000_0100, 16'h0, 26'h0);
    check_eq("retgt_req", 32'(imem_req), 32'd1);
    check_eq("retgt_addr", imem_addr, 32'h0000_2000);
    do_fetch(32'h0000_2000, 32'h0022_1820, "retgt");
    accept();

    // Response timeout: fetch_err after 255 waiting cycles
    wait_req(32'h0000_2004, "to_req");
    imem_ack = 1'b1;
    @(negedge clock);
    imem_ack = 1'b0;
    cycles = 0;
    while (!fetch_err && cycles < 300) begin
      @(negedge clock);
      cycles++;
    end
    check_eq("to_err", 32'(fetch_err), 32'd1);
    check_eq("to_cycles", 32'(cycles), 32'd255);

    // Sticky error across the refetch; then async reset mid-WAIT
    wait_req(32'h0000_2004, "refetch");
    check_eq("err_sticky", 32'(fetch_err), 32'd1);
    imem_ack = 1'b1;
    @(negedge clock);
    imem_ack = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_req", 32'(imem_req), 32'd0);
    check_eq("arst_err", 32'(fetch_err), 32'd0);
    check_eq("arst_inst", inst, 32'd0);
    check_eq("arst_pc", inst_pc, 32'd0);
    check_eq("arst_valid", 32'(inst_valid), 32'd0);
    @(negedge clock);
    reset_n     = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0BAD;
    @(negedge clock);
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    check_eq("post_rst_valid", 32'(inst_valid), 32'd0);
    do_fetch(32'h0000_0000, 32'h0000_0020, "post_rst");
    accept();

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
